// File: rtl/fifo_pkt_writer.sv
// Stream-to-FIFO packet writer: forwards payload beats, then appends a
// modulo checksum byte and a beat-count byte to every packet.
module fifo_pkt_writer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  write_clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic                  fifo_full,
   output logic                  write_en,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pkt_count
);

   typedef enum logic [1:0] {
      ST_DATA = 2'd0,
      ST_CSUM = 2'd1,
      ST_LEN  = 2'd2
   } state_t;

   state_t                state;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] len;
   logic                  load_slot;

   // The output register may take a new item when empty or draining this cycle.
   assign write_en   = out_valid & ~fifo_full;
   assign load_slot  = ~out_valid | write_en;
   assign write_data = out_data;
   // Gated by rst_n so in_ready drops the instant reset asserts.
   assign in_ready   = rst_n & load_slot & (state == ST_DATA);
   assign busy       = (state != ST_DATA) | out_valid;

   always_ff @(posedge write_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_DATA;
         out_valid <= 1'b0;
         out_data  <= '0;
         sum       <= '0;
         len       <= '0;
         pkt_count <= '0;
      end else if (load_slot) begin
         unique case (state)
            ST_DATA: begin
               if (in_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  sum       <= sum + in_data;
                  len       <= len + DATA_WIDTH'(1);
                  if (in_last) state <= ST_CSUM;
               end else begin
                  out_valid <= 1'b0;
               end
            end
            ST_CSUM: begin
               out_valid <= 1'b1;
               out_data  <= sum;
               state     <= ST_LEN;
            end
            ST_LEN: begin
               out_valid <= 1'b1;
               out_data  <= len;
               sum       <= '0;
               len       <= '0;
               pkt_count <= pkt_count + CNT_WIDTH'(1);
               state     <= ST_DATA;
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_DATA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Randomized bench for fifo_pkt_writer against a packet-level model of the
// expected FIFO write stream (payload, checksum, length).
module tb_fifo_pkt_writer;

   logic        write_clk = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data   = '0;
   logic        in_last   = 1'b0;
   logic        fifo_full = 1'b0;
   logic        write_en;
   logic [7:0]  write_data;
   logic        busy;
   logic [15:0] pkt_count;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          pkts  = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          got_cyc[$];
   logic        s_ready, s_we, s_busy;
   logic [7:0]  s_wdata;

   fifo_pkt_writer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .write_clk (write_clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .fifo_full (fifo_full),
      .write_en  (write_en),
      .write_data(write_data),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   always #5 write_clk = ~write_clk;
   always @(posedge write_clk) cyc <= cyc + 1;

   // Every FIFO write the DUT commits at the next rising edge.
   always @(negedge write_clk) begin
      if (write_en) begin
         got_q.push_back(write_data);
         got_cyc.push_back(cyc);
      end
   end

   // Expected writes for a packet: payload, then sum and count mod 256.
   task automatic model_pkt(input logic [7:0] b[$]);
      int s = 0;
      foreach (b[k]) begin
         exp_q.push_back(b[k]);
         s = s + int'(b[k]);
      end
      exp_q.push_back(8'(s % 256));
      exp_q.push_back(8'(b.size() % 256));
      pkts++;
   endtask

   function automatic bit same_q();
      if (got_q.size() != exp_q.size()) return 1'b0;
      foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void clear_q();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endfunction

   // One clock cycle: drive at posedge+1, sample at negedge, return at posedge+1.
   task automatic beat_cycle(input logic v, input logic [7:0] d, input logic l,
                             input logic f, output logic acc);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      fifo_full = f;
      @(negedge write_clk);
      s_ready = in_ready;
      s_we    = write_en;
      s_wdata = write_data;
      s_busy  = busy;
      acc     = v & in_ready;
      @(posedge write_clk);
      #1;
   endtask

   task automatic drive_pkt(input logic [7:0] b[$], input int gap, input int full);
      int   i = 0;
      int   n = 0;
      logic v, acc;
      model_pkt(b);
      while (i < b.size() && n < 5000) begin
         v = ($urandom_range(99, 0) >= gap);
         beat_cycle(v, v ? b[i] : 8'($urandom), v ? (i == b.size() - 1) : 1'($urandom),
                    ($urandom_range(99, 0) < full), acc);
         if (acc) i++;
         n++;
      end
      if (i < b.size()) begin
         fails++;
         $display("FAIL drive_pkt timeout: accepted %0d beats, required %0d", i, b.size());
      end
   endtask

   task automatic drain();
      int   n = 0;
      logic acc;
      do begin
         beat_cycle(1'b0, 8'($urandom), 1'($urandom), 1'b0, acc);
         n++;
      end while ((got_q.size() < exp_q.size() || s_busy) && n < 2000);
      tests++;
      if (n >= 2000) begin
         fails++;
         $display("FAIL drain timeout: got %0d writes, required %0d", got_q.size(), exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge write_clk);
      #1;
      tests++;
      if (in_ready !== 1'b0 || write_en !== 1'b0 || write_data !== 8'h00 || pkt_count !== 16'h0) begin
         fails++;
         $display("FAIL reset_values: rdy=%b we=%b wd=%h cnt=%h, required 0 0 00 0000",
                  in_ready, write_en, write_data, pkt_count);
      end
      @(negedge write_clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL after_release: rdy=%b busy=%b, required 1 0", in_ready, busy);
      end
      @(posedge write_clk);
      #1;
      pkts = 0;
      clear_q();
   endtask

   task automatic test_basic();
      logic [7:0] b[$] = '{8'h01, 8'h02, 8'h03};
      clear_q();
      drive_pkt(b, 0, 0);
      drain();
      tests++;
      if (!same_q() || got_q[3] !== 8'h06 || got_q[4] !== 8'h03) begin
         fails++;
         $display("FAIL basic_seq: %0d writes %p, required 01 02 03 06 03", got_q.size(), got_q);
      end
      tests++;
      if (got_cyc.size() != 5 || got_cyc[4] != got_cyc[0] + 4) begin
         fails++;
         $display("FAIL basic_consecutive: cycles %p, required 5 consecutive", got_cyc);
      end
      tests++;
      if (pkt_count !== 16'd1) begin
         fails++;
         $display("FAIL basic_count: got %0d, required 1", pkt_count);
      end
   endtask

   task automatic test_single();
      logic       acc;
      logic [7:0] b[$] = '{8'hFF};
      clear_q();
      model_pkt(b);
      beat_cycle(1'b1, 8'hFF, 1'b1, 1'b0, acc);
      tests++;
      if (acc !== 1'b1) begin
         fails++;
         $display("FAIL single_accept: got %b, required 1", acc);
      end
      for (int k = 0; k < 2; k++) begin
         beat_cycle(1'b1, 8'h5A, 1'b0, 1'b0, acc);
         tests++;
         if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_trailer_ready[%0d]: got %b, required 0", k, s_ready);
         end
      end
      beat_cycle(1'b0, 8'h5A, 1'b1, 1'b0, acc);
      tests++;
      if (s_ready !== 1'b1) begin
         fails++;
         $display("FAIL single_ready_back: got %b, required 1", s_ready);
      end
      drain();
      tests++;
      if (!same_q()) begin
         fails++;
         $display("FAIL single_seq: %p, required ff ff 01", got_q);
      end
   endtask

   task automatic test_stall();
      logic       acc;
      logic [7:0] b[$];
      clear_q();
      for (int k = 0; k < 4; k++) b.push_back(8'($urandom));
      model_pkt(b);
      beat_cycle(1'b1, b[0], 1'b0, 1'b0, acc);
      beat_cycle(1'b1, b[1], 1'b0, 1'b0, acc);
      for (int k = 0; k < 5; k++) begin
         beat_cycle(1'b1, b[2], 1'b0, 1'b1, acc);
         tests++;
         if (s_we !== 1'b0 || s_ready !== 1'b0 || s_wdata !== b[1]) begin
            fails++;
            $display("FAIL stall[%0d]: we=%b rdy=%b wd=%h, required 0 0 %h", k, s_we, s_ready, s_wdata, b[1]);
         end
      end
      beat_cycle(1'b1, b[2], 1'b0, 1'b0, acc);
      tests++;
      if (acc !== 1'b1 || s_we !== 1'b1) begin
         fails++;
         $display("FAIL stall_release: acc=%b we=%b, required 1 1", acc, s_we);
      end
      beat_cycle(1'b1, b[3], 1'b1, 1'b0, acc);
      drain();
      tests++;
      if (!same_q()) begin
         fails++;
         $display("FAIL stall_seq: %p, required %p", got_q, exp_q);
      end
   endtask

   task automatic test_long();
      logic [7:0] b[$];
      clear_q();
      for (int k = 0; k < 256; k++) b.push_back(8'h01);
      drive_pkt(b, 0, 0);
      drain();
      tests++;
      if (got_q.size() != 258) begin
         fails++;
         $display("FAIL long_count: got %0d writes, required 258", got_q.size());
      end else if (got_q[256] !== 8'h00 || got_q[257] !== 8'h00 || !same_q()) begin
         fails++;
         $display("FAIL long_trailer: csum=%h len=%h, required 00 00", got_q[256], got_q[257]);
      end
   endtask

   task automatic test_reset_mid();
      logic       acc;
      logic [7:0] b[$] = '{8'h10};
      clear_q();
      beat_cycle(1'b1, 8'hA1, 1'b0, 1'b0, acc);
      beat_cycle(1'b1, 8'hA2, 1'b0, 1'b0, acc);
      in_valid = 1'b0;
      tests++;
      if (write_en !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre_reset_we: got %b, required 1", write_en);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (write_en !== 1'b0 || in_ready !== 1'b0 || pkt_count !== 16'h0) begin
         fails++;
         $display("FAIL mid_async_reset: we=%b rdy=%b cnt=%0d, required 0 0 0", write_en, in_ready, pkt_count);
      end
      @(posedge write_clk);
      @(negedge write_clk);
      rst_n = 1'b1;
      @(posedge write_clk);
      #1;
      pkts = 0;
      clear_q();
      drive_pkt(b, 0, 0);
      drain();
      repeat (10) beat_cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
      tests++;
      if (!same_q()) begin
         fails++;
         $display("FAIL mid_next_pkt: %p, required 10 10 01", got_q);
      end
      tests++;
      if (pkt_count !== 16'd1) begin
         fails++;
         $display("FAIL mid_count: got %0d, required 1", pkt_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a[$];
      logic [7:0] b[$];
      clear_q();
      for (int k = 0; k < 3; k++) a.push_back(8'($urandom));
      for (int k = 0; k < 2; k++) b.push_back(8'($urandom));
      drive_pkt(a, 0, 0);
      drive_pkt(b, 0, 0);
      drain();
      tests++;
      if (!same_q()) begin
         fails++;
         $display("FAIL b2b_seq: %p, required %p", got_q, exp_q);
      end
      tests++;
      if (got_cyc.size() < 6 || got_cyc[5] != got_cyc[4] + 1) begin
         fails++;
         $display("FAIL b2b_gap: cycles %p, required second pkt right after length", got_cyc);
      end
      tests++;
      if (pkt_count !== 16'(pkts)) begin
         fails++;
         $display("FAIL b2b_count: got %0d, required %0d", pkt_count, pkts);
      end
   endtask

   task automatic test_random();
      logic [7:0] b[$];
      clear_q();
      for (int p = 0; p < 25; p++) begin
         b.delete();
         for (int k = 0; k < int'($urandom_range(12, 1)); k++) b.push_back(8'($urandom));
         drive_pkt(b, 25, 35);
      end
      drain();
      tests++;
      if (!same_q()) begin
         fails++;
         $display("FAIL random_seq: got %0d writes, required %0d", got_q.size(), exp_q.size());
      end
      tests++;
      if (pkt_count !== 16'(pkts)) begin
         fails++;
         $display("FAIL random_count: got %0d, required %0d", pkt_count, pkts);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_stall();
      test_long();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_pkt_writer.md
FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of stream and FIFO write data; equals the FIFO RAM_WIDTH.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the completed-packet counter.
REQ-003 SHALL have port write_clk, input, 1: sole clock, shared with the FIFO write side.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: upstream beat valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts beat this cycle.
REQ-007 SHALL have port in_data, input, DATA_WIDTH: upstream payload byte.
REQ-008 SHALL have port in_last, input, 1: beat is final payload beat of packet.
REQ-009 SHALL have port fifo_full, input, 1: FIFO full flag, write_clk domain.
REQ-010 SHALL have port write_en, output, 1: FIFO write strobe.
REQ-011 SHALL have port write_data, output, DATA_WIDTH: FIFO write data.
REQ-012 SHALL have port busy, output, 1: high while state is not DATA or the output register holds an item.
REQ-013 SHALL have port pkt_count, output, CNT_WIDTH: completed packets written, wraps modulo 2^CNT_WIDTH.

Function
REQ-014 SHALL hold one output register (out_valid, out_data); write_data = out_data; write_en = out_valid AND NOT fifo_full, combinational.
REQ-015 SHALL load the output register on any cycle where out_valid=0 or write_en=1 ("load slot"); on a load slot with nothing to load, SHALL clear out_valid.
REQ-016 SHALL implement FSM states DATA, CSUM, LEN; reset state DATA.
REQ-017 in DATA: in_ready = load slot; a transfer (in_valid AND in_ready) SHALL load in_data into the output register, so the beat appears on write_data one cycle after acceptance.
REQ-018 in DATA: each transfer SHALL add in_data to sum register modulo 2^DATA_WIDTH and increment length register modulo 2^DATA_WIDTH.
REQ-019 transfer with in_last=1 SHALL move FSM to CSUM; otherwise FSM stays DATA.
REQ-020 in CSUM and LEN: in_ready SHALL be 0.
REQ-021 in CSUM on a load slot: load sum (including the last beat) into the output register, move to LEN.
REQ-022 in LEN on a load slot: load length (payload beat count, modulo 2^DATA_WIDTH) into the output register, clear sum and length to 0, increment pkt_count, move to DATA.
REQ-023 Each packet of N payload beats SHALL produce exactly N+2 FIFO writes in order: payload, checksum, length.
REQ-024 While fifo_full=1, write_en SHALL be 0, out_data SHALL hold, and no beat or trailer SHALL be lost or duplicated.
REQ-025 fifo_full deasserting SHALL allow write_en in the same cycle; no bubble inserted when downstream is never full (one write per cycle sustained).
REQ-026 A 256-beat packet (DATA_WIDTH=8) SHALL report length 0x00.
REQ-027 in_data/in_last SHALL be ignored when no transfer occurs.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, write_en=0, in_ready=0, FSM=DATA, sum=0, length=0, pkt_count=0, out_data=0.
REQ-029 Reset mid-packet SHALL discard the partial packet; no trailer SHALL be written after release.
REQ-030 First cycle after release: in_ready=1, busy=0.

Verification
REQ-031 Packet 0x01,0x02,0x03 (last on 0x03), fifo_full=0 -> writes 0x01,0x02,0x03,0x06,0x03 on consecutive cycles; pkt_count=1.
REQ-032 Single beat 0xFF with last -> writes 0xFF,0xFF,0x01; in_ready=0 for 2 cycles after acceptance.
REQ-033 fifo_full=1 for 5 cycles during payload beat 2 of 4 -> write_en=0 those cycles, in_ready=0, write_data held, final write sequence identical to unstalled case.
REQ-034 256 beats of 0x01 -> checksum 0x00, length 0x00, 258 writes total.
REQ-035 rst_n pulsed low after 2 beats of a packet -> write_en drops asynchronously; next packet 0x10 last -> writes 0x10,0x10,0x01 only; pkt_count=1.
REQ-036 Back-to-back packets with in_valid held high -> second packet's first beat written cycle after first packet's length byte; pkt_count=2.
